// File: rtl/some_logic_pkg.sv
// Shared constants and helpers for the three-input Boolean function unit.
// The default table encodes out = a ? ~b : ~(b ^ c), indexed by {a,b,c}.
package some_logic_pkg;

   localparam logic [7:0] SOME_LOGIC_TT_DEFAULT = 8'h39;

   // An unknown index yields X in 4-state simulation, so bad stimulus is never masked.
   function automatic logic tt_lookup(input logic [7:0] tt, input logic [2:0] idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/some_logic_reg.sv
// Resettable output register with a one-cycle change flag.
// chg is high in the same cycle that q takes a value different from its previous one.
module some_logic_reg (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic chg
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q   <= 1'b0;
         chg <= 1'b0;
      end else begin
         q   <= d;
         chg <= (d != q);
      end
   end

endmodule

// File: rtl/some_logic_fn.sv
// Three-input table-driven Boolean function with an optional registered copy.
// Ports a, b, c, out lead the list so legacy positional instances still bind.
module some_logic_fn
   import some_logic_pkg::*;
#(
   parameter     TRUTH   = SOME_LOGIC_TT_DEFAULT,
   parameter bit REG_OUT = 1'b1
) (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic out,
   output logic out_q,
   output logic out_chg,
   input  logic clk,
   input  logic reset_n
);

   // TRUTH is left untyped so an override of the wrong width is caught here, not truncated.
   if ($bits(TRUTH) != 8) begin : g_bad_truth
      $error("some_logic_fn: TRUTH must be exactly 8 bits wide");
   end

   always_comb begin
      out = tt_lookup(TRUTH, {a, b, c});
   end

   if (REG_OUT) begin : g_reg
      some_logic_reg u_reg (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (out),
         .q       (out_q),
         .chg     (out_chg)
      );
   end else begin : g_noreg
      assign out_q   = 1'b0;
      assign out_chg = 1'b0;
   end

endmodule

// File: tb/tb_some_logic_fn.sv
// Self-checking bench for some_logic_fn: combinational table, registered path,
// async reset and a TRUTH override, with a scoreboard for the registered outputs.
module tb_some_logic_fn;

   logic clk = 1'b0;
   logic reset_n;
   logic a, b, c;
   logic out, out_q, out_chg;
   logic out_ff, out_q_ff, out_chg_ff;

   int n_chk  = 0;
   int n_pass = 0;

   // Expected {out_q, out_chg} after the next rising edge
   logic [1:0] sb[$];
   logic       m_q;

   always #5 clk = ~clk;

   some_logic_fn dut (
      .a       (a),
      .b       (b),
      .c       (c),
      .out     (out),
      .out_q   (out_q),
      .out_chg (out_chg),
      .clk     (clk),
      .reset_n (reset_n)
   );

   some_logic_fn #(.TRUTH(8'hFF), .REG_OUT(1'b0)) dut_ff (
      .a       (a),
      .b       (b),
      .c       (c),
      .out     (out_ff),
      .out_q   (out_q_ff),
      .out_chg (out_chg_ff),
      .clk     (clk),
      .reset_n (reset_n)
   );

   function automatic logic ref_fn(input logic [2:0] abc);
      if ($isunknown(abc)) return 1'bx;
      return abc[2] ? ~abc[1] : ~(abc[1] ^ abc[0]);
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
   endtask

   // Drive inputs in the low phase, check out at once, then check the registered
   // outputs one rising edge later against the scoreboard.
   task automatic run_cycle(input logic [2:0] abc, input string tag);
      logic nq;
      logic [1:0] e;
      {a, b, c} = abc;
      #1;
      nq = ref_fn(abc);
      check_bit({tag, ".out"}, out, nq);
      sb.push_back({nq, nq != m_q});
      m_q = nq;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_bit({tag, ".sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = sb.pop_front();
         check_bit({tag, ".out_q"}, out_q, e[1]);
         check_bit({tag, ".out_chg"}, out_chg, e[0]);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      {a, b, c} = 3'b000;
      m_q = 1'b0;
      @(posedge clk);
      #1;

      // Exhaustive combinational sweep, reset held so registers stay cleared
      for (int i = 0; i < 8; i++) begin
         {a, b, c} = 3'(i);
         #10;
         check_bit($sformatf("sweep%0d.out", i), out, ref_fn(3'(i)));
         check_bit($sformatf("sweep%0d.out_q_rst", i), out_q, 1'b0);
      end

      // Reset held across several edges with inputs 000
      {a, b, c} = 3'b000;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_bit("rst_hold.out", out, 1'b1);
         check_bit("rst_hold.out_q", out_q, 1'b0);
         check_bit("rst_hold.out_chg", out_chg, 1'b0);
      end

      // Release between edges; first edge loads 1 and flags the change once
      reset_n = 1'b1;
      m_q = 1'b0;
      run_cycle(3'b000, "rel0");
      run_cycle(3'b000, "rel1");
      run_cycle(3'b011, "s011");
      run_cycle(3'b110, "s110");
      run_cycle(3'b110, "s110b");

      // Alternating and random stimulus: out_chg may stay high back to back
      run_cycle(3'b000, "alt0");
      run_cycle(3'b001, "alt1");
      run_cycle(3'b000, "alt2");
      for (int i = 0; i < 24; i++) begin
         run_cycle(3'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
      end

      // Async reset mid-cycle with out_q known high
      run_cycle(3'b100, "pre_rst");
      #2;
      reset_n = 1'b0;
      #1;
      check_bit("async_rst.out_q", out_q, 1'b0);
      check_bit("async_rst.out_chg", out_chg, 1'b0);
      check_bit("async_rst.out", out, 1'b1);
      sb.delete();
      m_q = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      // That edge registered 100 -> 1 with a change flag
      check_bit("post_rst.out_q", out_q, 1'b1);
      check_bit("post_rst.out_chg", out_chg, 1'b1);
      m_q = 1'b1;
      run_cycle(3'b100, "post_rst2");

      // TRUTH override and the REG_OUT=0 tie-off
      {a, b, c} = 3'b110;
      #1;
      check_bit("ff.out", out_ff, 1'b1);
      check_bit("ff.out_q", out_q_ff, 1'b0);
      check_bit("ff.out_chg", out_chg_ff, 1'b0);
      check_bit("def110.out", out, 1'b0);

      // Unknown input must propagate to out
      a = 1'bx;
      b = 1'b0;
      c = 1'b0;
      #1;
      check_bit("x_in.out", out, ref_fn({a, b, c}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/some_logic_fn.md
# some_logic_fn

Three-input Boolean function unit: combinational output `out` implements a fixed 3-variable truth table, out = a ? ~b : ~(b ^ c). A registered copy `out_q` is provided for clocked consumers. The block is a leaf used wherever a single-bit decision on three control bits is needed. The module is `some_logic_fn`, with positional port order a, b, c, out kept for drop-in use as `some_logic`.

## Interface
Parameters:
- `TRUTH`, default 8'h39: truth table, bit index = {a,b,c}. Default sets minterms 0, 3, 4, 5.
- `REG_OUT`, default 1: 1 instantiates the `out_q` register; 0 ties `out_q` to 0.

Ports:
- `clk`, in, 1: rising-edge clock, used only by the registered path.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `a`, in, 1: function input, MSB of index.
- `b`, in, 1: function input.
- `c`, in, 1: function input, LSB of index.
- `out`, out, 1: combinational result, TRUTH[{a,b,c}].
- `out_q`, out, 1: `out` registered on `clk`.
- `out_chg`, out, 1: registered pulse, 1 for one cycle when `out_q` changes value.

Positional order for legacy use: a, b, c, out. `clk` and `reset_n` are connected by name.

## Operation
Default truth table, {a,b,c} -> out:
- 000 -> 1
- 001 -> 0
- 010 -> 0
- 011 -> 1
- 100 -> 1
- 101 -> 1
- 110 -> 0
- 111 -> 0

Combinational path:
- `out` is a pure function of a, b, c, with no dependence on `clk` or `reset_n`.
- X/Z on any input drives `out` to X. No silent default is allowed, so 4-state checks with === catch bad stimulus.

Registered path:
- `out_q` <= `out` on every rising `clk`.
- `out_chg` <= (`out` != `out_q`).

Reset:
- `reset_n` low forces `out_q` = 0 and `out_chg` = 0 immediately, with no clock needed.
- Reset does not affect `out`.
- First edge after release: `out_q` loads `out`, and `out_chg` flags it if `out` = 1.

## Timing
- `out`: zero-cycle latency. It must settle within 10 ns of any input change in simulation, with no delays in the RTL.
- `out_q`: one-cycle latency from input change to registered value.
- `out_chg`: asserted in the same cycle that `out_q` takes its new value, for exactly one cycle per transition.
- Reset asserted mid-operation clears `out_q` and `out_chg` asynchronously.
- Reset release is synchronized externally. The block samples normally from the first clean edge.
- Inputs changing every cycle: `out_q` tracks them cycle by cycle, and `out_chg` may stay high for consecutive cycles.

## Structure
- Package `some_logic_pkg`:
  - constant `SOME_LOGIC_TT_DEFAULT` = 8'h39
  - function `tt_lookup(tt, idx)` returning one bit
- Sub-module `some_logic_reg`: the reset-able output register plus the change detector.
- Top module holds the lookup and an elaboration check that `TRUTH` is 8 bits wide.

## Test plan
- Exhaustive sweep, 10 ns per step, inputs 000 to 111 -> `out` = 1,0,0,1,1,1,0,0, checked with ===.
- Hold `reset_n` = 0 with clock running and a,b,c = 000 -> `out_q` = 0, `out_chg` = 0, while `out` = 1.
- Release reset with a,b,c = 000 -> `out_q` = 1 after the first edge, `out_chg` = 1 for that one cycle only.
- Step 011 -> 110 -> `out` falls immediately, `out_q` falls one edge later, `out_chg` pulses once.
- Assert `reset_n` low between edges -> `out_q` = 0 without waiting for a clock edge.
- Override `TRUTH` = 8'hFF with a,b,c = 110 -> `out` = 1.
- Drive a = X -> `out` = X.
